// File: rtl/cix32_prefetch_queue.sv
// cix32_prefetch_queue
// Instruction byte producer for the x86 decode stage. Fetches aligned 32-bit
// code words into a circular byte queue and presents up to 15 linear bytes.
// The presented window is held until the decoder reports its length, then
// that many bytes are retired. A flush redirects the fetch stream.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   o_fetch_req/_addr     code read request, word-aligned address
//   i_fetch_ack/_data     read completion, little-endian code word
//   i_flush/_addr         redirect to a new linear IP (any alignment)
//   o_bytes_out           window bytes, byte i at [i*8+:8], zero beyond valid
//   o_valid_bytes         min(count, 15)
//   o_out_valid           window presented, i_out_ready accepts it
//   o_head_addr           linear address of o_bytes_out[7:0]
//   i_consume_valid/_len  decoded length to retire (1..15)
//   o_consume_err         sticky illegal-consume flag
module cix32_prefetch_queue #(
  parameter int unsigned QUEUE_BYTES  = 32,
  parameter int unsigned PRESENT_MIN  = 15,
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic         o_fetch_req,
  output logic [31:0]  o_fetch_addr,
  input  logic         i_fetch_ack,
  input  logic [31:0]  i_fetch_data,
  input  logic         i_flush,
  input  logic [31:0]  i_flush_addr,
  output logic [127:0] o_bytes_out,
  output logic [3:0]   o_valid_bytes,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [31:0]  o_head_addr,
  input  logic         i_consume_valid,
  input  logic [3:0]   i_consume_len,
  output logic         o_consume_err
);

  localparam int unsigned PTR_W     = $clog2(QUEUE_BYTES);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned WIN_BYTES = 15;

  localparam logic [0:0] S_PRESENT = 1'b0;
  localparam logic [0:0] S_WAIT    = 1'b1;

  logic [0:0]       r_state,      w_state_next;
  logic [CNT_W-1:0] r_count,      w_count_next;
  logic [PTR_W-1:0] r_rd_ptr,     w_rd_ptr_next;
  logic [PTR_W-1:0] r_wr_ptr,     w_wr_ptr_next;
  logic [31:0]      r_fetch_addr, w_fetch_addr_next;
  logic [31:0]      r_head_addr,  w_head_addr_next;
  logic [1:0]       r_skip,       w_skip_next;
  logic             r_fetch_req,  w_fetch_req_next;
  logic             r_consume_err, w_consume_err_next;
  logic [3:0]       r_win_bytes,  w_win_bytes_next;
  logic [7:0]       r_mem [QUEUE_BYTES];

  logic             w_fetch_req;
  logic             w_ack;
  logic [CNT_W-1:0] w_wr_len;
  logic [CNT_W-1:0] w_ret_len;
  logic [3:0]       w_valid_bytes;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_consume_ok;
  logic             w_consume_bad;
  logic [127:0]     w_bytes_out;

  // Request is suppressed in the flush cycle so an ack there is never taken.
  always_comb begin
    w_fetch_req   = r_fetch_req & ~i_flush;
    w_ack         = w_fetch_req & i_fetch_ack;
    w_wr_len      = w_ack ? CNT_W'(3'd4 - 3'(r_skip)) : '0;
    w_valid_bytes = (r_count >= CNT_W'(WIN_BYTES)) ? 4'(WIN_BYTES) : 4'(r_count);
    w_out_valid   = (r_state == S_PRESENT) && (r_count >= CNT_W'(PRESENT_MIN));
    w_accept      = w_out_valid & i_out_ready;
    w_consume_ok  = (r_state == S_WAIT) && i_consume_valid &&
                    (i_consume_len != 4'd0) && (i_consume_len <= r_win_bytes);
    w_consume_bad = i_consume_valid & ~w_consume_ok;
    w_ret_len     = w_consume_ok ? CNT_W'(i_consume_len) : '0;
  end

  // Next-state logic: flush wins over ack, accept and consume.
  always_comb begin
    w_state_next       = r_state;
    w_count_next       = r_count;
    w_rd_ptr_next      = r_rd_ptr;
    w_wr_ptr_next      = r_wr_ptr;
    w_fetch_addr_next  = r_fetch_addr;
    w_head_addr_next   = r_head_addr;
    w_skip_next        = r_skip;
    w_fetch_req_next   = r_fetch_req;
    w_consume_err_next = r_consume_err;
    w_win_bytes_next   = r_win_bytes;

    if (i_flush) begin
      w_state_next      = S_PRESENT;
      w_count_next      = '0;
      w_rd_ptr_next     = '0;
      w_wr_ptr_next     = '0;
      w_head_addr_next  = i_flush_addr;
      w_fetch_addr_next = {i_flush_addr[31:2], 2'b00};
      w_skip_next       = i_flush_addr[1:0];
      w_fetch_req_next  = 1'b1;
    end else begin
      case (r_state)
        S_PRESENT: begin
          if (w_accept) begin
            w_state_next     = S_WAIT;
            w_win_bytes_next = w_valid_bytes;
          end
        end
        S_WAIT: begin
          if (w_consume_ok) begin
            w_state_next = S_PRESENT;
          end
        end
        default: w_state_next = S_PRESENT;
      endcase

      if (w_consume_bad) begin
        w_consume_err_next = 1'b1;
      end
      if (w_consume_ok) begin
        w_rd_ptr_next    = r_rd_ptr + PTR_W'(i_consume_len);
        w_head_addr_next = r_head_addr + 32'(i_consume_len);
      end
      if (w_ack) begin
        w_wr_ptr_next     = r_wr_ptr + PTR_W'(w_wr_len);
        w_fetch_addr_next = r_fetch_addr + 32'd4;
        w_skip_next       = 2'b00;
      end

      w_count_next     = r_count + w_wr_len - w_ret_len;
      // A new request only when a whole word is guaranteed to fit.
      w_fetch_req_next = (CNT_W'(QUEUE_BYTES) - w_count_next) >= CNT_W'(4);
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_PRESENT;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_fetch_addr  <= {RESET_VECTOR[31:2], 2'b00};
      r_head_addr   <= RESET_VECTOR;
      r_skip        <= RESET_VECTOR[1:0];
      r_fetch_req   <= 1'b0;
      r_consume_err <= 1'b0;
      r_win_bytes   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_fetch_addr  <= w_fetch_addr_next;
      r_head_addr   <= w_head_addr_next;
      r_skip        <= w_skip_next;
      r_fetch_req   <= w_fetch_req_next;
      r_consume_err <= w_consume_err_next;
      r_win_bytes   <= w_win_bytes_next;
    end
  end

  // Byte storage: the leading r_skip bytes of the first word after a redirect are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_ack) begin
      for (int j = 0; j < 4; j++) begin
        if (2'(j) >= r_skip) begin
          r_mem[r_wr_ptr + PTR_W'(j) - PTR_W'(r_skip)] <= i_fetch_data[j*8 +: 8];
        end
      end
    end
  end

  // Presented window, zero-filled beyond the valid bytes.
  always_comb begin
    w_bytes_out = '0;
    for (int unsigned i = 0; i < WIN_BYTES; i++) begin
      if (4'(i) < w_valid_bytes) begin
        w_bytes_out[i*8 +: 8] = r_mem[r_rd_ptr + PTR_W'(i)];
      end
    end
  end

  assign o_fetch_req   = w_fetch_req;
  assign o_fetch_addr  = r_fetch_addr;
  assign o_bytes_out   = w_bytes_out;
  assign o_valid_bytes = w_valid_bytes;
  assign o_out_valid   = w_out_valid;
  assign o_head_addr   = r_head_addr;
  assign o_consume_err = r_consume_err;

endmodule
